// File: rtl/adc_cal_loop_pipe.sv
// adc_cal_loop_pipe
//   Multi-channel ADC -> calibrate -> DAC loop. Each channel is box-car averaged
//   over 2^shift samples. A shared 3-stage pipeline then applies per-channel
//   signed gain/offset, saturation and offset-binary encoding. All DAC codes and
//   saturation flags update together in a single UPDATE cycle.
// Ports
//   ADC_CLK       sole clock
//   RST           asynchronous active-high reset
//   ENABLE        run request (level)
//   ADC_DATA_IN   one signed sample per channel per cycle
//   AVG_SHIFT     averaging exponent, clamped to MAX_AVG_LOG2
//   GAIN_IN       per-channel signed gain, FRAC_WIDTH fractional bits
//   OFFSET_IN     per-channel signed offset in DAC LSBs
//   DAC_CODE_OUT  registered offset-binary DAC codes
//   SAT_OUT       per-channel saturation flags of the last frame
//   DONE          one-cycle pulse when the outputs update
//   BUSY          high whenever the controller is not idle
//   FRAME_CNT     completed-frame counter (wraps)
module adc_cal_loop_pipe #(
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned ADC_WIDTH    = 12,
    parameter int unsigned DAC_WIDTH    = 14,
    parameter int unsigned GAIN_WIDTH   = 24,
    parameter int unsigned FRAC_WIDTH   = 16,
    parameter int unsigned OFFSET_WIDTH = 16,
    parameter int unsigned MAX_AVG_LOG2 = 10
) (
    input  logic                             ADC_CLK,
    input  logic                             RST,
    input  logic                             ENABLE,
    input  logic [CHANNELS*ADC_WIDTH-1:0]    ADC_DATA_IN,
    input  logic [4:0]                       AVG_SHIFT,
    input  logic [CHANNELS*GAIN_WIDTH-1:0]   GAIN_IN,
    input  logic [CHANNELS*OFFSET_WIDTH-1:0] OFFSET_IN,
    output logic [CHANNELS*DAC_WIDTH-1:0]    DAC_CODE_OUT,
    output logic [CHANNELS-1:0]              SAT_OUT,
    output logic                             DONE,
    output logic                             BUSY,
    output logic [15:0]                      FRAME_CNT
);
    localparam int unsigned AccW   = ADC_WIDTH + MAX_AVG_LOG2;
    localparam int unsigned CntW   = MAX_AVG_LOG2 + 1;
    localparam int unsigned PW     = ADC_WIDTH + GAIN_WIDTH;
    localparam int unsigned YW0    = ((PW - FRAC_WIDTH) > OFFSET_WIDTH) ? (PW - FRAC_WIDTH)
                                                                        : OFFSET_WIDTH;
    // One spare bit so offset addition cannot wrap.
    localparam int unsigned YW     = ((YW0 > DAC_WIDTH) ? YW0 : DAC_WIDTH) + 1;
    localparam int unsigned ChIdxW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned CalW   = $clog2(CHANNELS + 2);

    localparam logic [DAC_WIDTH-1:0] MidCode = {1'b1, {(DAC_WIDTH-1){1'b0}}};
    localparam logic signed [YW-1:0] YMax    = YW'((2 ** (DAC_WIDTH - 1)) - 1);
    localparam logic signed [YW-1:0] YMin    = ~YMax;

    typedef enum logic [1:0] {StIdle, StAccum, StCal, StUpdate} state_e;

    state_e state_q, state_d;

    logic [4:0]                     shift_q;
    logic signed [GAIN_WIDTH-1:0]   gain_q [CHANNELS];
    logic signed [OFFSET_WIDTH-1:0] off_q  [CHANNELS];
    logic signed [AccW-1:0]         acc_q  [CHANNELS];
    logic [CntW-1:0]                cnt_q;
    logic [CalW-1:0]                cal_cnt_q;

    logic                           v1_q, v2_q;
    logic [ChIdxW-1:0]              ch1_q, ch2_q;
    logic signed [PW-1:0]           p1_q;
    logic signed [YW-1:0]           y2_q;
    logic [DAC_WIDTH-1:0]           code_sh_q [CHANNELS];
    logic [CHANNELS-1:0]            sat_sh_q;

    logic [CHANNELS*DAC_WIDTH-1:0]  dac_q;
    logic [CHANNELS-1:0]            sat_q;
    logic                           done_q;
    logic [15:0]                    frame_q;

    // FSM control
    logic busy, latch_cfg, acc_clr, acc_add, cal_issue, cal_last, upd;
    logic cnt_last;
    logic [CntW-1:0] cnt_tgt;
    logic [4:0] shift_clamped;

    // Datapath
    logic [ChIdxW-1:0]           ch_sel;
    logic signed [ADC_WIDTH-1:0] avg;
    logic signed [PW-1:0]        p1_d;
    logic signed [YW-1:0]        y2_d;
    logic signed [YW-1:0]        clamp_v;
    logic                        sat_v;
    logic [DAC_WIDTH-1:0]        code_v;

    assign shift_clamped = (AVG_SHIFT > 5'(MAX_AVG_LOG2)) ? 5'(MAX_AVG_LOG2) : AVG_SHIFT;
    assign cnt_tgt       = (CntW'(1) << shift_q) - CntW'(1);
    assign cnt_last      = (cnt_q == cnt_tgt);
    assign cal_last      = (cal_cnt_q == CalW'(CHANNELS + 1));

    always_ff @(posedge ADC_CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (ENABLE) state_d = StAccum;
            StAccum: begin
                if (!ENABLE)       state_d = StIdle;
                else if (cnt_last) state_d = StCal;
            end
            StCal:    if (cal_last) state_d = StUpdate;
            StUpdate: state_d = ENABLE ? StAccum : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q != StIdle);
        latch_cfg = ((state_q == StIdle) || (state_q == StUpdate)) && ENABLE;
        acc_clr   = (state_q == StIdle) || (state_q == StUpdate) ||
                    ((state_q == StAccum) && !ENABLE);
        acc_add   = (state_q == StAccum) && ENABLE;
        cal_issue = (state_q == StCal) && (cal_cnt_q < CalW'(CHANNELS));
        upd       = (state_q == StUpdate);
    end

    // S1 reads the channel being issued; S2/S3 follow the index down the pipe.
    always_comb begin
        ch_sel  = ChIdxW'(cal_cnt_q);
        avg     = ADC_WIDTH'(acc_q[ch_sel] >>> shift_q);
        p1_d    = PW'(avg) * PW'(gain_q[ch_sel]);
        y2_d    = YW'(p1_q >>> FRAC_WIDTH) + YW'(off_q[ch1_q]);
        clamp_v = y2_q;
        sat_v   = 1'b0;
        if (y2_q > YMax) begin
            clamp_v = YMax;
            sat_v   = 1'b1;
        end else if (y2_q < YMin) begin
            clamp_v = YMin;
            sat_v   = 1'b1;
        end
        code_v  = DAC_WIDTH'(clamp_v) ^ MidCode;
    end

    always_ff @(posedge ADC_CLK or posedge RST) begin
        if (RST) begin
            shift_q   <= '0;
            cnt_q     <= '0;
            cal_cnt_q <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            ch1_q     <= '0;
            ch2_q     <= '0;
            p1_q      <= '0;
            y2_q      <= '0;
            sat_sh_q  <= '0;
            sat_q     <= '0;
            done_q    <= 1'b0;
            frame_q   <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                gain_q[c]    <= '0;
                off_q[c]     <= '0;
                acc_q[c]     <= '0;
                code_sh_q[c] <= '0;
                dac_q[c*DAC_WIDTH +: DAC_WIDTH] <= MidCode;
            end
        end else begin
            if (latch_cfg) begin
                shift_q <= shift_clamped;
                for (int c = 0; c < CHANNELS; c++) begin
                    gain_q[c] <= GAIN_IN[c*GAIN_WIDTH +: GAIN_WIDTH];
                    off_q[c]  <= OFFSET_IN[c*OFFSET_WIDTH +: OFFSET_WIDTH];
                end
            end

            if (acc_clr) begin
                cnt_q <= '0;
                for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
            end else if (acc_add) begin
                cnt_q <= cnt_last ? '0 : cnt_q + CntW'(1);
                for (int c = 0; c < CHANNELS; c++) begin
                    acc_q[c] <= acc_q[c] + AccW'($signed(ADC_DATA_IN[c*ADC_WIDTH +: ADC_WIDTH]));
                end
            end

            cal_cnt_q <= (state_q == StCal) ? cal_cnt_q + CalW'(1) : '0;

            v1_q <= cal_issue;
            if (cal_issue) begin
                ch1_q <= ch_sel;
                p1_q  <= p1_d;
            end
            v2_q <= v1_q;
            if (v1_q) begin
                ch2_q <= ch1_q;
                y2_q  <= y2_d;
            end
            if (v2_q) begin
                code_sh_q[ch2_q] <= code_v;
                sat_sh_q[ch2_q]  <= sat_v;
            end

            done_q <= upd;
            if (upd) begin
                sat_q   <= sat_sh_q;
                frame_q <= frame_q + 16'd1;
                for (int c = 0; c < CHANNELS; c++) begin
                    dac_q[c*DAC_WIDTH +: DAC_WIDTH] <= code_sh_q[c];
                end
            end
        end
    end

    assign DAC_CODE_OUT = dac_q;
    assign SAT_OUT      = sat_q;
    assign DONE         = done_q;
    assign BUSY         = busy;
    assign FRAME_CNT    = frame_q;

endmodule

// File: tb/tb_adc_cal_loop_pipe.sv
// Bench for adc_cal_loop_pipe (CHANNELS=2, default widths). A frame-level
// reference model predicts every output on every cycle; directed frames add
// hand-computed literal expectations.
module tb_adc_cal_loop_pipe;
    localparam int CH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic [4:0] shift_in = 5'd2;
    int dv[2] = '{0, 0};
    int gv[2] = '{65536, 65536};
    int ov[2] = '{0, 0};

    logic [23:0] adc_data;
    logic [47:0] gain_in;
    logic [31:0] off_in;
    logic [27:0] dac;
    logic [1:0]  sat;
    logic        done, busy;
    logic [15:0] fcnt;

    assign adc_data = {12'(dv[1]), 12'(dv[0])};
    assign gain_in  = {24'(gv[1]), 24'(gv[0])};
    assign off_in   = {16'(ov[1]), 16'(ov[0])};

    adc_cal_loop_pipe dut (
        .ADC_CLK      (clk),
        .RST          (rst),
        .ENABLE       (en),
        .ADC_DATA_IN  (adc_data),
        .AVG_SHIFT    (shift_in),
        .GAIN_IN      (gain_in),
        .OFFSET_IN    (off_in),
        .DAC_CODE_OUT (dac),
        .SAT_OUT      (sat),
        .DONE         (done),
        .BUSY         (busy),
        .FRAME_CNT    (fcnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int     m_mode = 0;   // 0 idle, 1 collecting samples, 2 waiting for update
    int     m_n = 0, m_wt = 0, m_sh = 0;
    longint m_sum[2] = '{0, 0};
    longint m_g[2]   = '{0, 0};
    longint m_o[2]   = '{0, 0};
    int     exp_code[2] = '{8192, 8192};
    bit [1:0] exp_sat = 2'b00;
    bit     exp_done = 1'b0;
    int     exp_cnt = 0;
    bit     exp_busy = 1'b0;

    function automatic int cal_code(input longint sum, input int sh, input longint g,
                                    input longint o, output bit s);
        longint a, p, y;
        a = sum >>> sh;
        a = ((a & 64'hFFF) ^ 64'h800) - 64'h800;
        p = a * g;
        y = (p >>> 16) + o;
        s = 1'b0;
        if (y > 8191) begin y = 8191; s = 1'b1; end
        if (y < -8192) begin y = -8192; s = 1'b1; end
        return int'(y + 8192);
    endfunction

    task automatic model_latch();
        m_sh = (shift_in > 5'd10) ? 10 : int'(shift_in);
        for (int c = 0; c < CH; c++) begin
            m_g[c] = gv[c];
            m_o[c] = ov[c];
            m_sum[c] = 0;
        end
        m_n = 0;
        m_mode = 1;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_mode = 0; m_n = 0; m_wt = 0;
            m_sum = '{0, 0};
            exp_code = '{8192, 8192};
            exp_sat = 2'b00; exp_done = 1'b0; exp_cnt = 0;
        end else begin
            exp_done = 1'b0;
            case (m_mode)
                0: if (en) model_latch();
                1: begin
                    if (!en) begin
                        m_mode = 0;
                    end else begin
                        for (int c = 0; c < CH; c++) m_sum[c] += dv[c];
                        m_n++;
                        if (m_n == (1 << m_sh)) begin
                            m_mode = 2;
                            m_wt = CH + 3;
                        end
                    end
                end
                default: begin
                    m_wt--;
                    if (m_wt == 0) begin
                        for (int c = 0; c < CH; c++) begin
                            bit s;
                            exp_code[c] = cal_code(m_sum[c], m_sh, m_g[c], m_o[c], s);
                            exp_sat[c] = s;
                        end
                        exp_done = 1'b1;
                        exp_cnt = (exp_cnt + 1) & 16'hFFFF;
                        if (en) model_latch();
                        else m_mode = 0;
                    end
                end
            endcase
        end
        exp_busy = (m_mode != 0);
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        check("dac0", dac[13:0], exp_code[0]);
        check("dac1", dac[27:14], exp_code[1]);
        check("sat", sat, exp_sat);
        check("done", done, exp_done);
        check("frame_cnt", fcnt, exp_cnt);
        check("busy", busy, exp_busy);
    end

    // ---------------- stimulus ----------------
    int s0[1024];
    int s1[1024];

    // Runs one frame of n samples from idle; lat = negedges from the last
    // capture edge until DONE is seen (-1 if never).
    task automatic frame(input int sh, input int n, output int lat);
        int sg0, so0;
        sg0 = gv[0];
        so0 = ov[0];
        @(negedge clk);
        en = 1'b1;
        shift_in = 5'(sh);
        dv[0] = -999; dv[1] = 999;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            dv[0] = s0[i];
            dv[1] = s1[i];
            if (i == 1) begin
                gv[0] = sg0 + 12345;
                ov[0] = so0 + 77;
                shift_in = 5'd0;
            end
        end
        @(negedge clk);
        en = 1'b0;
        gv[0] = sg0;
        ov[0] = so0;
        dv[0] = 555; dv[1] = -555;
        lat = -1;
        for (int k = 0; k <= 20; k++) begin
            if (lat < 0 && done === 1'b1) lat = k;
            @(negedge clk);
        end
    endtask

    task automatic fill4(input int a0, b0, c0, d0, input int a1, b1, c1, d1);
        s0[0] = a0; s0[1] = b0; s0[2] = c0; s0[3] = d0;
        s1[0] = a1; s1[1] = b1; s1[2] = c1; s1[3] = d1;
    endtask

    initial begin
        int lat;
        int t[8];
        int nd;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_dac0", dac[13:0], 8192);
        check("rst_dac1", dac[27:14], 8192);
        check("rst_busy", busy, 0);
        check("rst_cnt", fcnt, 0);

        // Basic average
        gv = '{65536, 65536}; ov = '{0, 0};
        fill4(100, 102, 104, 106, -8, -8, -8, -8);
        frame(2, 4, lat);
        check("basic_code0", dac[13:0], 8295);
        check("basic_code1", dac[27:14], 8184);
        check("basic_latency", lat, 5);
        check("basic_cnt", fcnt, 1);
        check("basic_sat", sat, 0);

        // Gain and offset, negative gain on ch1
        gv = '{131072, -65536}; ov = '{-50, 20};
        frame(2, 4, lat);
        check("gain_code0", dac[13:0], 8348);
        check("gain_code1", dac[27:14], 8220);
        check("gain_sat", sat, 0);

        // Saturation at both rails
        gv = '{524288, 524288}; ov = '{0, 0};
        fill4(2047, 2047, 2047, 2047, -2048, -2048, -2048, -2048);
        frame(2, 4, lat);
        check("sat_code0", dac[13:0], 16383);
        check("sat_code1", dac[27:14], 0);
        check("sat_flags", sat, 3);

        // Floor on negative average
        gv = '{65536, 65536};
        s0[0] = -1; s0[1] = -2; s1[0] = 5; s1[1] = 6;
        frame(1, 2, lat);
        check("floor_code0", dac[13:0], 8190);
        check("floor_code1", dac[27:14], 8197);
        check("floor_sat", sat, 0);

        // Oversized exponent behaves as the maximum (1024 samples)
        for (int i = 0; i < 1024; i++) begin
            s0[i] = i % 8;
            s1[i] = -(i % 4);
        end
        frame(20, 1024, lat);
        check("clamp_code0", dac[13:0], 8195);
        check("clamp_code1", dac[27:14], 8190);
        check("clamp_latency", lat, 5);
        check("clamp_cnt", fcnt, 5);

        // Abort after 3 of 4 samples
        @(negedge clk);
        en = 1'b1; shift_in = 5'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dv[0] = 1000; dv[1] = 1000;
        end
        @(negedge clk);
        en = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_cnt", fcnt, 5);
        check("abort_busy", busy, 0);
        check("abort_code0", dac[13:0], 8195);
        fill4(10, 10, 10, 10, 0, 0, 0, 0);
        frame(2, 4, lat);
        check("post_abort_code0", dac[13:0], 8202);
        check("post_abort_code1", dac[27:14], 8192);
        check("post_abort_cnt", fcnt, 6);

        // Continuous run: DONE period
        @(negedge clk);
        en = 1'b1; shift_in = 5'd2;
        dv[0] = 500; dv[1] = -300;
        nd = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done === 1'b1 && nd < 8) begin
                t[nd] = k;
                nd++;
            end
        end
        en = 1'b0;
        repeat (12) @(negedge clk);
        check("cont_dones", (nd >= 3) ? 1 : 0, 1);
        if (nd >= 3) begin
            check("cont_period1", t[1] - t[0], 9);
            check("cont_period2", t[2] - t[1], 9);
        end
        check("cont_code0", dac[13:0], 8692);
        check("cont_code1", dac[27:14], 7892);

        // Reset during CAL
        fill4(300, 300, 300, 300, 40, 40, 40, 40);
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dv[0] = s0[i]; dv[1] = s1[i];
        end
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midcal_rst_dac0", dac[13:0], 8192);
        check("midcal_rst_dac1", dac[27:14], 8192);
        check("midcal_rst_done", done, 0);
        check("midcal_rst_busy", busy, 0);
        check("midcal_rst_cnt", fcnt, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("after_rst_cnt", fcnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
